// File: rtl/la_rle_pkg.sv
// rtl/la_rle_pkg.sv - shared types and defaults for the logic-analyser RLE encoder
package la_rle_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_CNT_W-1:0]  count;
    } rec_t;

endpackage

// File: rtl/la_rle_run_cnt.sv
// rtl/la_rle_run_cnt.sv - saturating run-length counter (count = run length - 1)
module la_rle_run_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_max_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign at_max_o = &count_q;
    assign count_o  = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !at_max_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/la_rle_encoder_p.sv
// rtl/la_rle_encoder_p.sv - run-length encoder collapsing identical samples into {data, count} records
module la_rle_encoder_p
    import la_rle_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLK_EN,
    input  logic              RLE_EN,
    input  logic              FLUSH,
    input  logic [DATA_W-1:0] CH_MASK,
    input  logic [DATA_W-1:0] LA_IN_DATA,
    output logic [DATA_W-1:0] LA_OUT_DATA,
    output logic [CNT_W-1:0]  LA_RLE_OUT_DATA,
    output logic              LA_SRAM_ADDR_CNT_EN,
    output logic              RUN_SAT
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic [DATA_W-1:0] out_data_q;
    logic [CNT_W-1:0]  out_cnt_q;
    logic              stb_q, sat_q;
    logic [CNT_W-1:0]  run_cnt;
    logic              at_max;
    logic              cnt_clr, cnt_inc;
    logic              emit, emit_sat;
    logic              match;

    la_rle_run_cnt #(.CNT_W(CNT_W)) u_run_cnt (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (cnt_clr),
        .inc_i    (cnt_inc),
        .count_o  (run_cnt),
        .at_max_o (at_max)
    );

    // Masked-off channels never break a run.
    assign match = ((LA_IN_DATA ^ s_q) & CH_MASK) == '0;

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        emit     = 1'b0;
        emit_sat = 1'b0;
        if (FLUSH) begin
            if (state_q == RUN) begin
                emit = 1'b1;
            end
            if (CLK_EN) begin
                state_d = RUN;
                s_d     = LA_IN_DATA;
                cnt_clr = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else if (CLK_EN) begin
            if (state_q == IDLE) begin
                state_d = RUN;
                s_d     = LA_IN_DATA;
                cnt_clr = 1'b1;
            end else if (RLE_EN && match && !at_max) begin
                cnt_inc = 1'b1;
            end else begin
                // Saturated run: the current sample opens the follow-on run.
                emit     = 1'b1;
                emit_sat = RLE_EN && match;
                s_d      = LA_IN_DATA;
                cnt_clr  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            s_q        <= '0;
            out_data_q <= '0;
            out_cnt_q  <= '0;
            stb_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            stb_q   <= emit;
            sat_q   <= emit_sat;
            if (emit) begin
                out_data_q <= s_q;
                out_cnt_q  <= run_cnt;
            end
        end
    end

    assign LA_OUT_DATA         = out_data_q;
    assign LA_RLE_OUT_DATA     = out_cnt_q;
    assign LA_SRAM_ADDR_CNT_EN = stb_q;
    assign RUN_SAT             = sat_q;

endmodule

// File: tb/tb_la_rle_encoder_p.sv
// tb/tb_la_rle_encoder_p.sv - self-checking bench for la_rle_encoder_p against a run-length model
module tb_la_rle_encoder_p;

    localparam int DW     = 8;
    localparam int CW     = 4;
    localparam int MAXLEN = 1 << CW;

    logic          CLK = 1'b0;
    logic          RST, CLK_EN, RLE_EN, FLUSH;
    logic [DW-1:0] CH_MASK, LA_IN_DATA;
    logic [DW-1:0] LA_OUT_DATA;
    logic [CW-1:0] LA_RLE_OUT_DATA;
    logic          LA_SRAM_ADDR_CNT_EN, RUN_SAT;

    la_rle_encoder_p #(.DATA_W(DW), .CNT_W(CW)) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .CLK_EN              (CLK_EN),
        .RLE_EN              (RLE_EN),
        .FLUSH               (FLUSH),
        .CH_MASK             (CH_MASK),
        .LA_IN_DATA          (LA_IN_DATA),
        .LA_OUT_DATA         (LA_OUT_DATA),
        .LA_RLE_OUT_DATA     (LA_RLE_OUT_DATA),
        .LA_SRAM_ADDR_CNT_EN (LA_SRAM_ADDR_CNT_EN),
        .RUN_SAT             (RUN_SAT)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Model: an open run is a first sample plus a length in samples.
    bit m_open = 0;
    int m_s    = 0;
    int m_len  = 0;
    int e_stb  = 0, e_sat = 0, e_data = 0, e_cnt = 0;
    int model_log[$];
    int exp_q[$];

    function automatic int enc(input int d, input int c, input int s);
        return d * 32 + c * 2 + s;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic record(input int d, input int len, input int sat);
        e_stb  = 1;
        e_sat  = sat;
        e_data = d;
        e_cnt  = len - 1;
        model_log.push_back(enc(d, len - 1, sat));
    endtask

    task automatic model_edge(input bit r, input bit ce, input bit rle, input bit fl,
                              input int m, input int x);
        e_stb = 0;
        e_sat = 0;
        if (r) begin
            m_open = 0; m_s = 0; m_len = 0; e_data = 0; e_cnt = 0;
        end else if (fl) begin
            if (m_open) record(m_s, m_len, 0);
            if (ce) begin m_open = 1; m_s = x; m_len = 1; end
            else m_open = 0;
        end else if (ce) begin
            if (!m_open) begin
                m_open = 1; m_s = x; m_len = 1;
            end else if (rle && ((x ^ m_s) & m) == 0) begin
                if (m_len < MAXLEN) m_len++;
                else begin record(m_s, m_len, 1); m_s = x; m_len = 1; end
            end else begin
                record(m_s, m_len, 0); m_s = x; m_len = 1;
            end
        end
    endtask

    task automatic compare_outputs();
        chk("strobe", int'(LA_SRAM_ADDR_CNT_EN), e_stb);
        chk("run_sat", int'(RUN_SAT), e_sat);
        chk("out_data", int'(LA_OUT_DATA), e_data);
        chk("out_count", int'(LA_RLE_OUT_DATA), e_cnt);
    endtask

    task automatic step(input bit r, input bit ce, input bit rle, input bit fl,
                        input logic [DW-1:0] m, input logic [DW-1:0] x);
        RST = r; CLK_EN = ce; RLE_EN = rle; FLUSH = fl; CH_MASK = m; LA_IN_DATA = x;
        @(posedge CLK);
        model_edge(r, ce, rle, fl, int'(m), int'(x));
        @(negedge CLK);
        compare_outputs();
    endtask

    task automatic check_log(input string name);
        chk({name, "_records"}, model_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < model_log.size(); i++)
            chk(name, model_log[i], exp_q[i]);
        model_log.delete();
    endtask

    logic [DW-1:0] rx, rm;

    initial begin
        RST = 1'b1; CLK_EN = 1'b0; RLE_EN = 1'b1; FLUSH = 1'b0;
        CH_MASK = '1; LA_IN_DATA = '0;
        @(negedge CLK);
        step(1, 0, 1, 0, 8'hFF, 8'h00);
        chk("reset_data", int'(LA_OUT_DATA), 0);
        chk("reset_count", int'(LA_RLE_OUT_DATA), 0);
        chk("reset_strobe", int'(LA_SRAM_ADDR_CNT_EN), 0);

        // Run of 0x55 closed by 0xAA
        model_log.delete();
        repeat (5) step(0, 1, 1, 0, 8'hFF, 8'h55);
        step(0, 1, 1, 0, 8'hFF, 8'hAA);
        step(0, 0, 1, 0, 8'hFF, 8'h00);
        exp_q = '{enc('h55, 4, 0)};
        check_log("t1_run");

        // Saturation split at 16 samples
        step(1, 0, 1, 0, 8'hFF, 8'h00);
        model_log.delete();
        repeat (20) step(0, 1, 1, 0, 8'hFF, 8'h11);
        step(0, 1, 1, 0, 8'hFF, 8'h22);
        step(0, 0, 1, 0, 8'hFF, 8'h00);
        exp_q = '{enc('h11, 15, 1), enc('h11, 3, 0)};
        check_log("t2_sat");

        // Raw mode with flush drain
        step(1, 0, 1, 0, 8'hFF, 8'h00);
        model_log.delete();
        step(0, 1, 0, 0, 8'hFF, 8'h01);
        step(0, 1, 0, 0, 8'hFF, 8'h02);
        step(0, 1, 0, 0, 8'hFF, 8'h02);
        step(0, 1, 0, 0, 8'hFF, 8'h03);
        step(0, 0, 0, 1, 8'hFF, 8'h00);
        step(0, 0, 0, 0, 8'hFF, 8'h00);
        exp_q = '{enc(1, 0, 0), enc(2, 0, 0), enc(2, 0, 0), enc(3, 0, 0)};
        check_log("t3_raw");

        // Channel mask keeps upper nibble out of the compare
        step(1, 0, 1, 0, 8'hFF, 8'h00);
        model_log.delete();
        step(0, 1, 1, 0, 8'h0F, 8'h10);
        step(0, 1, 1, 0, 8'h0F, 8'h20);
        step(0, 1, 1, 0, 8'h0F, 8'h30);
        step(0, 1, 1, 0, 8'h0F, 8'h31);
        step(0, 0, 1, 0, 8'h0F, 8'h00);
        exp_q = '{enc('h10, 2, 0)};
        check_log("t4_mask");

        // Flush with a concurrent sample reopens a run
        step(1, 0, 1, 0, 8'hFF, 8'h00);
        model_log.delete();
        repeat (3) step(0, 1, 1, 0, 8'hFF, 8'h7E);
        step(0, 1, 1, 1, 8'hFF, 8'h7E);
        step(0, 0, 1, 0, 8'hFF, 8'h00);
        step(0, 0, 1, 1, 8'hFF, 8'h00);
        step(0, 0, 1, 0, 8'hFF, 8'h00);
        exp_q = '{enc('h7E, 2, 0), enc('h7E, 0, 0)};
        check_log("t5_flush");

        // Reset mid-run discards the pending run
        repeat (4) begin
            step(0, 1, 1, 0, 8'hFF, 8'h33);
            step(0, 0, 1, 0, 8'hFF, 8'h33);
        end
        step(1, 0, 1, 0, 8'hFF, 8'h00);
        exp_q = {};
        check_log("t6_rst");
        chk("t6_data_zero", int'(LA_OUT_DATA), 0);
        chk("t6_count_zero", int'(LA_RLE_OUT_DATA), 0);
        step(0, 0, 1, 1, 8'hFF, 8'h00);
        chk("t6_flush_idle", int'(LA_SRAM_ADDR_CNT_EN), 0);

        // Randomised traffic with long runs
        rx = 8'h00;
        rm = 8'hFF;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0: rm = 8'hFF;
                    1: rm = 8'h0F;
                    2: rm = 8'h00;
                    default: rm = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 4) == 0)
                rx = {6'($urandom), 2'($urandom_range(0, 3))};
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) != 0, $urandom_range(0, 15) == 0, rm, rx);
            model_log.delete();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
